// File: rtl/combined_radix_stream.sv
// Serial negacyclic NTT/INTT core (radix-2/4/8, mod PRIME), one coefficient in
// and one out per clock, with a capture buffer and a separate drain buffer.
// Ports:
//   clock, reset_n                        rising-edge clock, async active-low reset
//   input_core_stream                     coefficient sample, highest index first
//   weight_1/2/3_stream                   per-sample weights captured with the sample
//   radix_mode, mode                      frame size and direction, taken on first sample
//   streaming_mode                        1 = accept a sample this cycle
//   output_core_stream                    result, natural order, 0 when idle
// Build option: define CR_INPUT_REDUCE_EN to reduce samples/weights mod PRIME
// on capture (negative values mapped into [0,PRIME-1]).
module combined_radix_stream #(
    parameter int WIDTH = 18,
    parameter int PRIME = 65537
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic signed [WIDTH-1:0] input_core_stream,
    input  logic signed [WIDTH-1:0] weight_1_stream,
    input  logic signed [WIDTH-1:0] weight_2_stream,
    input  logic signed [WIDTH-1:0] weight_3_stream,
    input  logic [1:0]              radix_mode,
    input  logic                    mode,
    input  logic                    streaming_mode,
    output logic signed [WIDTH-1:0] output_core_stream
);

    typedef logic [WIDTH-1:0]       word_t;
    typedef logic [2*WIDTH-1:0]     prod_t;
    typedef logic [7:0][WIDTH-1:0]  vec_t;

    localparam word_t P_W = word_t'(PRIME);
    localparam prod_t P_L = prod_t'(PRIME);

    function automatic word_t addmod(input word_t a, input word_t b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P_W}) s = s - {1'b0, P_W};
        return word_t'(s);
    endfunction

    function automatic word_t submod(input word_t a, input word_t b);
        logic [WIDTH:0] s;
        if (a >= b) s = {1'b0, a} - {1'b0, b};
        else        s = {1'b0, a} + {1'b0, P_W} - {1'b0, b};
        return word_t'(s);
    endfunction

    function automatic word_t modmul(input word_t a, input word_t b);
        prod_t p;
        p = prod_t'(a) * prod_t'(b);
        return word_t'(p % P_L);
    endfunction

    // Cooley-Tukey stage: (a, b) -> (a + w*b, a - w*b), w from the higher index.
    function automatic vec_t ct(input vec_t v, input int s, input vec_t w,
                                input logic unit);
        vec_t r;
        word_t t;
        logic [2:0] lo, hi;
        r = v;
        for (int j = 0; j < 8; j++) begin
            if ((j & s) == 0) begin
                lo = 3'(j);
                hi = 3'(j + s);
                t = unit ? v[hi] : modmul(w[hi], v[hi]);
                r[lo] = addmod(v[lo], t);
                r[hi] = submod(v[lo], t);
            end
        end
        return r;
    endfunction

    // Gentleman-Sande stage: (a, b) -> (a + b, (a - b)*w), w from the higher index.
    function automatic vec_t gs(input vec_t v, input int s, input vec_t w,
                                input logic unit);
        vec_t r;
        word_t d;
        logic [2:0] lo, hi;
        r = v;
        for (int j = 0; j < 8; j++) begin
            if ((j & s) == 0) begin
                lo = 3'(j);
                hi = 3'(j + s);
                d = submod(v[lo], v[hi]);
                r[lo] = addmod(v[lo], v[hi]);
                r[hi] = unit ? d : modmul(d, w[hi]);
            end
        end
        return r;
    endfunction

    // Size code 0/1/2 -> last element index of the frame.
    function automatic logic [2:0] last_of(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'd1;
            2'd1:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    word_t cx, c1, c2, c3;

`ifdef CR_INPUT_REDUCE_EN
    typedef logic signed [WIDTH+1:0] sext_t;
    localparam sext_t P_S = sext_t'(PRIME);

    function automatic word_t red_in(input logic signed [WIDTH-1:0] v);
        sext_t r;
        r = sext_t'(v) % P_S;
        if (r < 0) r = r + P_S;
        return word_t'(r);
    endfunction

    assign cx = red_in(input_core_stream);
    assign c1 = red_in(weight_1_stream);
    assign c2 = red_in(weight_2_stream);
    assign c3 = red_in(weight_3_stream);
`else
    assign cx = word_t'(input_core_stream);
    assign c1 = word_t'(weight_1_stream);
    assign c2 = word_t'(weight_2_stream);
    assign c3 = word_t'(weight_3_stream);
`endif

    logic [2:0] cnt_q, cnt_d;
    logic [1:0] sz_q, sz_d;
    logic       inv_q, inv_d;
    vec_t       bx_q, bx_d, b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
    logic       done_q, done_d;
    vec_t       res_q, res_d;
    logic [2:0] dlen_q, dlen_d;
    logic [2:0] didx_q, didx_d;
    logic       dact_q, dact_d;
    word_t      out_q, out_d;

    logic [1:0] sz_in, sz_cur;
    logic [2:0] last, wr;
    vec_t       tv;

    // Radix code 11 behaves as radix-8.
    assign sz_in = radix_mode[1] ? 2'd2 : {1'b0, radix_mode[0]};

    // Capture: first sample of a frame lands at index N-1, last at index 0.
    always_comb begin
        cnt_d  = cnt_q;
        sz_d   = sz_q;
        inv_d  = inv_q;
        bx_d   = bx_q;
        b1_d   = b1_q;
        b2_d   = b2_q;
        b3_d   = b3_q;
        done_d = 1'b0;
        sz_cur = (cnt_q == 3'd0) ? sz_in : sz_q;
        last   = last_of(sz_cur);
        wr     = last - cnt_q;
        if (streaming_mode) begin
            bx_d[wr] = cx;
            b1_d[wr] = c1;
            b2_d[wr] = c2;
            b3_d[wr] = c3;
            if (cnt_q == 3'd0) begin
                sz_d  = sz_in;
                inv_d = mode;
            end
            if (cnt_q == last) begin
                cnt_d  = 3'd0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    // Transform of the captured frame. Lanes beyond N compute garbage that
    // is never drained.
    always_comb begin
        tv = bx_q;
        if (!inv_q) begin
            for (int i = 0; i < 8; i++) begin
                tv[3'(i)] = modmul(bx_q[3'(i)], b1_q[3'(i)]);
            end
            tv = ct(tv, 1, b1_q, 1'b1);
            if (sz_q != 2'd0) tv = ct(tv, 2, b2_q, 1'b0);
            if (sz_q == 2'd2) tv = ct(tv, 4, b3_q, 1'b0);
        end else begin
            case (sz_q)
                2'd0: begin
                    tv = gs(tv, 1, b1_q, 1'b0);
                end
                2'd1: begin
                    tv = gs(tv, 2, b1_q, 1'b0);
                    tv = gs(tv, 1, b2_q, 1'b0);
                end
                default: begin
                    tv = gs(tv, 4, b1_q, 1'b0);
                    tv = gs(tv, 2, b2_q, 1'b0);
                    tv = gs(tv, 1, b1_q, 1'b1);
                end
            endcase
            for (int i = 0; i < 8; i++) begin
                tv[3'(i)] = modmul(tv[3'(i)], b3_q[3'(i)]);
            end
        end
    end

    // Drain: a completed frame is latched one cycle after its last sample,
    // then emitted from index 0. A new load in the same cycle as the last
    // drained element keeps the stream gapless.
    always_comb begin
        res_d  = res_q;
        dlen_d = dlen_q;
        didx_d = didx_q;
        dact_d = dact_q;
        out_d  = '0;
        if (dact_q) begin
            out_d = res_q[didx_q];
            if (didx_q == dlen_q) dact_d = 1'b0;
            else                  didx_d = didx_q + 3'd1;
        end
        if (done_q) begin
            res_d  = tv;
            dlen_d = last_of(sz_q);
            didx_d = 3'd0;
            dact_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            sz_q   <= '0;
            inv_q  <= 1'b0;
            bx_q   <= '0;
            b1_q   <= '0;
            b2_q   <= '0;
            b3_q   <= '0;
            done_q <= 1'b0;
            res_q  <= '0;
            dlen_q <= '0;
            didx_q <= '0;
            dact_q <= 1'b0;
            out_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sz_q   <= sz_d;
            inv_q  <= inv_d;
            bx_q   <= bx_d;
            b1_q   <= b1_d;
            b2_q   <= b2_d;
            b3_q   <= b3_d;
            done_q <= done_d;
            res_q  <= res_d;
            dlen_q <= dlen_d;
            didx_q <= didx_d;
            dact_q <= dact_d;
            out_q  <= out_d;
        end
    end

    assign output_core_stream = out_q;

endmodule

// File: tb/tb_combined_radix_stream.sv
// Directed bench for combined_radix_stream: hand-computed frames,
// back-to-back frames, input pauses and an asynchronous reset mid-frame.
module tb_combined_radix_stream;

    localparam int W = 18;

    logic                clk = 1'b0;
    logic                rst_n;
    logic signed [W-1:0] din, w1, w2, w3, dout;
    logic [1:0]          rmode;
    logic                md, sm;

    always #5 clk = ~clk;

    combined_radix_stream #(.WIDTH(W), .PRIME(65537)) dut (
        .clock              (clk),
        .reset_n            (rst_n),
        .input_core_stream  (din),
        .weight_1_stream    (w1),
        .weight_2_stream    (w2),
        .weight_3_stream    (w3),
        .radix_mode         (rmode),
        .mode               (md),
        .streaming_mode     (sm),
        .output_core_stream (dout)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    c;
        int    v;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int fx[8], fw1[8], fw2[8], fw3[8], fe[8];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: compare the output at the negedge of its due cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
            chk(exp_q[0].tag, 32'(dout), 32'(exp_q[0].v));
            void'(exp_q.pop_front());
        end
    end

    task automatic fill_w(input int a, input int b, input int c);
        for (int i = 0; i < 8; i++) begin
            fw1[i] = a;
            fw2[i] = b;
            fw3[i] = c;
        end
    endtask

    // Sends x[n-1]..x[0]; later samples carry bogus radix/mode values that
    // must be ignored. gap_at inserts a paused cycle with junk before x[gap_at].
    task automatic frame(input string name, input int n, input logic [1:0] rm,
                         input logic m, input int gap_at);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            if (i == gap_at) begin
                sm = 1'b0;
                din = 12345;
                w1 = 777;
                w2 = 888;
                w3 = 999;
                rmode = ~rm;
                md = ~m;
                @(posedge clk);
                #1;
            end
            sm = 1'b1;
            din = W'(fx[i]);
            w1 = W'(fw1[i]);
            w2 = W'(fw2[i]);
            w3 = W'(fw3[i]);
            rmode = (i == n - 1) ? rm : (rm ^ 2'b10);
            md = (i == n - 1) ? m : ~m;
            @(posedge clk);
            #1;
            if (i == 0) begin
                for (int k = 0; k < n; k++) begin
                    e.c = cyc + 2 + k;
                    e.v = fe[k];
                    e.tag = $sformatf("%s_X%0d", name, k);
                    exp_q.push_back(e);
                end
            end
        end
        sm = 1'b0;
        din = '0;
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 40 && exp_q.size() > 0; t++) @(posedge clk);
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk({name, "_idle"}, 32'(dout), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        sm = 1'b0;
        din = '0;
        w1 = '0;
        w2 = '0;
        w3 = '0;
        rmode = 2'b00;
        md = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 32'(dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Radix-2 NTT, unit weights
        fx = '{3, 5, 0, 0, 0, 0, 0, 0};
        fill_w(1, 1, 1);
        fe = '{8, 65535, 0, 0, 0, 0, 0, 0};
        frame("r2_ntt", 2, 2'b00, 1'b0, -1);
        wait_drain("r2_ntt");

        // Radix-2 NTT with psi pre-twist and a paused cycle
        fx = '{3, 5, 0, 0, 0, 0, 0, 0};
        fill_w(1, 1, 1);
        fw1[1] = 4;
        fe = '{23, 65520, 0, 0, 0, 0, 0, 0};
        frame("r2_psi", 2, 2'b00, 1'b0, 0);
        wait_drain("r2_psi");

        // Radix-2 INTT round trip
        fx = '{8, 65535, 0, 0, 0, 0, 0, 0};
        fill_w(1, 1, 32769);
        fe = '{3, 5, 0, 0, 0, 0, 0, 0};
        frame("r2_intt", 2, 2'b00, 1'b1, -1);
        wait_drain("r2_intt");

        // Radix-4 impulse
        fx = '{1, 0, 0, 0, 0, 0, 0, 0};
        fill_w(1, 1, 1);
        fe = '{1, 1, 1, 1, 0, 0, 0, 0};
        frame("r4_imp", 4, 2'b01, 1'b0, 2);
        wait_drain("r4_imp");

        // Radix-8 NTT then INTT back-to-back (INTT uses radix code 11)
        fx = '{0, 4, 2, 6, 1, 5, 3, 7};
        fill_w(1, 16, 256);
        fw1 = '{1, 4, 16, 64, 256, 1024, 4096, 16384};
        fe = '{64252, 771, 1275, 64772, 14629, 53470, 50982, 11997};
        frame("r8_ntt", 8, 2'b10, 1'b0, -1);
        fx = '{64252, 771, 1275, 64772, 14629, 53470, 50982, 11997};
        fill_w(65281, 61441, 1);
        fw3 = '{57345, 63489, 65025, 65409, 65505, 65529, 65535, 32768};
        fe = '{0, 4, 2, 6, 1, 5, 3, 7};
        frame("r8_intt", 8, 2'b11, 1'b1, 3);
        wait_drain("r8_rt");

        // Three back-to-back radix-2 frames, one with a pause
        fx = '{3, 5, 0, 0, 0, 0, 0, 0};
        fill_w(1, 1, 1);
        fe = '{8, 65535, 0, 0, 0, 0, 0, 0};
        frame("b2b_a", 2, 2'b00, 1'b0, -1);
        fx = '{10, 2, 0, 0, 0, 0, 0, 0};
        fe = '{12, 8, 0, 0, 0, 0, 0, 0};
        frame("b2b_b", 2, 2'b00, 1'b0, 0);
        fx = '{12, 8, 0, 0, 0, 0, 0, 0};
        fill_w(1, 1, 32769);
        fe = '{10, 2, 0, 0, 0, 0, 0, 0};
        frame("b2b_c", 2, 2'b00, 1'b1, -1);
        wait_drain("b2b");

        // Async reset during a drain and a partial radix-4 frame
        fx = '{3, 5, 0, 0, 0, 0, 0, 0};
        fill_w(1, 1, 1);
        fe = '{8, 65535, 0, 0, 0, 0, 0, 0};
        frame("pre_rst", 2, 2'b00, 1'b0, -1);
        for (int i = 0; i < 2; i++) begin
            sm = 1'b1;
            din = 9;
            rmode = 2'b01;
            md = 1'b0;
            @(posedge clk);
            #1;
        end
        sm = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_async_out", 32'(dout), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_out", 32'(dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_out", 32'(dout), 32'd0);
        fx = '{2, 1, 0, 0, 0, 0, 0, 0};
        fill_w(1, 1, 1);
        fe = '{3, 1, 3, 1, 0, 0, 0, 0};
        frame("post_rst", 4, 2'b01, 1'b0, -1);
        wait_drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
